// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encodings, default slice geometry and
// the index-width helper used by the multi-precision add sequencer.
package alu_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int N_DEF     = 32;
    localparam int WORDS_DEF = 4;

    // Word-index width; a single-word operand still gets a 1-bit counter.
    function automatic int idx_width(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/nbit_adder_core.sv
// Purely combinational N-bit adder slice with carry-in and carry-out.
module nbit_adder_core #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one N-bit slice, LS word first, WORDS clocks per op.
// Define ALU_SUB_EN to add the in_sub port (A - B via inverted B and carry-in 1).
module mp_add_seq
    import alu_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    input  logic               in_cin,
`ifdef ALU_SUB_EN
    input  logic               in_sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_cout
);

    localparam int             IW   = idx_width(WORDS);
    localparam logic [IW-1:0]  LAST = IW'(WORDS - 1);

    logic [1:0]                 state;
    logic [IW-1:0]              idx;
    logic                       carry;
    logic [WORDS-1:0][N-1:0]    a_w;
    logic [WORDS-1:0][N-1:0]    b_w;
    logic [WORDS-1:0][N-1:0]    sum_w;
    logic [N*WORDS-1:0]         b_cap;
    logic                       cin_cap;
    logic [N-1:0]               s;
    logic                       c;

    // Subtraction is A + ~B + 1; the inversion happens once at capture.
`ifdef ALU_SUB_EN
    assign b_cap   = in_sub ? ~in_b : in_b;
    assign cin_cap = in_sub ? 1'b1 : in_cin;
`else
    assign b_cap   = in_b;
    assign cin_cap = in_cin;
`endif

    nbit_adder_core #(.N(N)) u_add (
        .a    (a_w[idx]),
        .b    (b_w[idx]),
        .cin  (carry),
        .sum  (s),
        .cout (c)
    );

    assign in_ready = (state == S_IDLE);
    assign out_sum  = sum_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_w       <= '0;
            b_w       <= '0;
            sum_w     <= '0;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_w   <= in_a;
                        b_w   <= b_cap;
                        carry <= cin_cap;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_w[idx] <= s;
                    carry      <= c;
                    if (idx == LAST) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        out_cout  <= c;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq at N=8, WORDS=4; subtract vectors need ALU_SUB_EN.
module tb_mp_add_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef ALU_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int checks = 0;
    int errors = 0;

    mp_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ALU_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one op, measure latency to out_valid, check result, then drain.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout);
        int lat;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(out_cout), 64'(exp_cout));
        tick();
        check({tag, "_idle"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    initial begin
        int  cnt;
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
`ifdef ALU_SUB_EN
        in_sub    = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);

        run_op("t1", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
        run_op("t2", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
        run_op("tcin", 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0);

        // Backpressure: result held, new requests ignored.
        out_ready = 1'b0;
        in_a      = 32'h80000000;
        in_b      = 32'h80000000;
        in_cin    = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_a = 32'h00000001;
        in_b = 32'h00000001;
        cnt  = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("bp_lat", 64'(cnt), 64'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", 64'({out_valid, in_ready, out_cout, out_sum}),
                  64'({1'b1, 1'b0, 1'b1, 32'h00000000}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", 64'({in_ready, out_valid}), 64'b10);

        // Reset mid-RUN at idx=2 drops the op.
        in_a     = 32'h00000001;
        in_b     = 32'h00000001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", 64'({in_ready, out_valid, out_cout, out_sum}),
              64'({1'b1, 1'b0, 1'b0, 32'h0}));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("mid_rst_no_result", 64'(seen), 64'd0);

        // Back-to-back with in_valid held high.
        in_a     = 32'h01010101;
        in_b     = 32'h02020202;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        tick();
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("b2b_sum1", 64'({out_cout, out_sum}), 64'({1'b0, 32'h03030303}));
        in_a = 32'hF0000000;
        in_b = 32'h10000000;
        while (!in_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        tick();
        cnt++;
        check("b2b_spacing", 64'(cnt), 64'd6);
        check("b2b_accept2", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("b2b_lat2", 64'(cnt), 64'd4);
        check("b2b_sum2", 64'({out_cout, out_sum}), 64'({1'b1, 32'h00000000}));
        tick();

`ifdef ALU_SUB_EN
        in_sub = 1'b1;
        run_op("sub1", 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b1);
        run_op("sub2", 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0);
        in_sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
